mem_access_unit: RTL and testbench

Unified instruction/data memory responder for the multicycle RV32 core. Consumes the memory-side control strobes from the control FSM (Address_Src, Inst_Write, Mem_Write, Store_type, Load_type) and performs the following:
- instruction fetch into the instruction register;
- `sw`/`sb` stores with byte lanes;
- `lw`/`lbu` loads into a memory data register.

It sits between the datapath (PC, ALU result, rs2 data) and the result mux, and also provides a boot-load port for preloading the program image.

---
 rtl/mem_access_unit.sv | 108 ++++++++++
 tb/tb_mem_access_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Unified instruction/data memory responder for the multicycle RV32 core:
// fetches into the IR, performs sw/sb stores and lw/lbu loads, and accepts a boot-load image.
module mem_access_unit #(
    parameter int          ADDR_W    = 7,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALU_Result,
    input  logic [31:0]       Write_Data,
    input  logic              Address_Src,
    input  logic              Inst_Write,
    input  logic              Mem_Write,
    input  logic              Store_type,
    input  logic              Load_type,
    input  logic              Boot_We,
    input  logic [ADDR_W-3:0] Boot_Addr,
    input  logic [31:0]       Boot_Data,
    output logic [31:0]       Instr,
    output logic [31:0]       Read_Data,
    output logic              Misalign,
    output logic              Bad_Access,
    output logic [7:0]        Store_Count
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    logic [31:0]       mem_q [WORDS];
    logic [31:0]       instr_q, read_data_q;
    logic              misalign_q, bad_access_q;
    logic [7:0]        store_count_q, store_count_d;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-3:0] widx, wsel;
    logic [1:0]        off;
    logic [31:0]       rd_word, wdata;
    logic [7:0]        rd_byte;
    logic [3:0]        be;
    logic              store_req, load_cap, wr_full, wr_byte, commit;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        addr      = Address_Src ? ALU_Result : PC;
        widx      = addr[ADDR_W-1:2];
        off       = addr[1:0];
        rd_word   = mem_q[widx];
        rd_byte   = rd_word[{off, 3'b000} +: 8];

        store_req = RST && Mem_Write && Address_Src;
        load_cap  = Address_Src && !Mem_Write;
        wr_full   = store_req && Store_type && (off == 2'd0);
        wr_byte   = store_req && !Store_type;
        commit    = wr_full || wr_byte;

        be    = 4'b0000;
        wsel  = widx;
        wdata = Write_Data;
        if (!RST) begin
            if (Boot_We) begin
                be    = 4'b1111;
                wsel  = Boot_Addr;
                wdata = Boot_Data;
            end
        end else if (wr_full) begin
            be = 4'b1111;
        end else if (wr_byte) begin
            be    = 4'b0001 << off;
            wdata = {4{Write_Data[7:0]}};
        end

        store_count_d = store_count_q;
        if (commit && store_count_q != 8'hFF) store_count_d = store_count_q + 8'd1;
    end

    // NOTE: the RAM array has no reset; only the boot port and committed stores ever change it.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[wsel][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // NOTE: state registers use non-blocking assignments, so a capture on a word being stored sees the old data.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            instr_q       <= NOP_INSTR;
            read_data_q   <= 32'd0;
            misalign_q    <= 1'b0;
            bad_access_q  <= 1'b0;
            store_count_q <= 8'd0;
        end else begin
            if (Inst_Write && !Address_Src) instr_q <= rd_word;
            // The extended load result is registered directly rather than the raw word plus offset.
            if (load_cap) read_data_q <= Load_type ? {24'd0, rd_byte} : rd_word;
            if ((load_cap && !Load_type && off != 2'd0) ||
                (store_req && Store_type && off != 2'd0)) misalign_q <= 1'b1;
            if (Mem_Write && !Address_Src) bad_access_q <= 1'b1;
            store_count_q <= store_count_d;
        end
    end

    assign Instr       = instr_q;
    assign Read_Data   = read_data_q;
    assign Misalign    = misalign_q;
    assign Bad_Access  = bad_access_q;
    assign Store_Count = store_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a byte-addressed model is compared every cycle,
// plus literal expectations from hand-computed values.
module tb_mem_access_unit;

    logic        CLK, RST;
    logic [6:0]  PC, ALU_Result;
    logic [31:0] Write_Data;
    logic        Address_Src, Inst_Write, Mem_Write, Store_type, Load_type, Boot_We;
    logic [4:0]  Boot_Addr;
    logic [31:0] Boot_Data;
    logic [31:0] Instr, Read_Data;
    logic        Misalign, Bad_Access;
    logic [7:0]  Store_Count;

    mem_access_unit #(.ADDR_W(7), .NOP_INSTR(32'h00000013)) dut (
        .CLK(CLK), .RST(RST), .PC(PC), .ALU_Result(ALU_Result), .Write_Data(Write_Data),
        .Address_Src(Address_Src), .Inst_Write(Inst_Write), .Mem_Write(Mem_Write),
        .Store_type(Store_type), .Load_type(Load_type), .Boot_We(Boot_We),
        .Boot_Addr(Boot_Addr), .Boot_Data(Boot_Data), .Instr(Instr), .Read_Data(Read_Data),
        .Misalign(Misalign), .Bad_Access(Bad_Access), .Store_Count(Store_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte-addressed memory and the five architectural outputs.
    logic [7:0]  m_mem [128];
    logic [31:0] m_instr, m_rd;
    logic        m_mis, m_bad;
    int          m_cnt;
    bit          m_valid = 0;

    function automatic logic [31:0] m_word(input int base);
        return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    endfunction

    task automatic model_step();
        int a, base;
        logic [31:0] w;
        if (!RST) begin
            if (Boot_We)
                for (int k = 0; k < 4; k++) m_mem[int'(Boot_Addr)*4 + k] = Boot_Data[8*k +: 8];
            m_instr = 32'h00000013; m_rd = 0; m_mis = 0; m_bad = 0; m_cnt = 0;
        end else begin
            a    = int'(Address_Src ? ALU_Result : PC);
            base = a - (a % 4);
            w    = m_word(base);
            if (Inst_Write && !Address_Src) m_instr = w;
            if (Address_Src && !Mem_Write) begin
                m_rd = Load_type ? {24'd0, m_mem[a]} : w;
                if (!Load_type && a % 4 != 0) m_mis = 1;
            end
            if (Mem_Write) begin
                if (!Address_Src) m_bad = 1;
                else if (Store_type) begin
                    if (a % 4 != 0) m_mis = 1;
                    else begin
                        for (int k = 0; k < 4; k++) m_mem[a + k] = Write_Data[8*k +: 8];
                        if (m_cnt < 255) m_cnt++;
                    end
                end else begin
                    m_mem[a] = Write_Data[7:0];
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        m_valid = 1;
    endtask

    // Compare process: every cycle, away from the rising edge.
    initial forever begin
        @(negedge CLK);
        if (m_valid) begin
            check("instr", Instr, m_instr);
            check("read_data", Read_Data, m_rd);
            check("misalign", {31'd0, Misalign}, {31'd0, m_mis});
            check("bad_access", {31'd0, Bad_Access}, {31'd0, m_bad});
            check("store_count", {24'd0, Store_Count}, m_cnt[31:0]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle();
        RST = 1; Address_Src = 0; Inst_Write = 0; Mem_Write = 0;
        Store_type = 0; Load_type = 0; Boot_We = 0;
    endtask

    task automatic store(input int a, input logic [31:0] d, input logic is_sw);
        idle(); Address_Src = 1; Mem_Write = 1; Store_type = is_sw;
        ALU_Result = 7'(a); Write_Data = d; tick();
    endtask

    task automatic load(input int a, input logic is_lbu);
        idle(); Address_Src = 1; Load_type = is_lbu; ALU_Result = 7'(a); tick();
        idle(); tick();   // Memory state: Address_Src back to 0, result must hold
    endtask

    task automatic fetch(input int a);
        idle(); Inst_Write = 1; PC = 7'(a); tick();
    endtask

    initial begin
        idle(); RST = 0; PC = 0; ALU_Result = 0; Write_Data = 0; Boot_Addr = 0; Boot_Data = 0;
        for (int i = 0; i < 32; i++) begin
            Boot_We = 1; Boot_Addr = 5'(i);
            Boot_Data = (i == 0) ? 32'h00500093 : (i == 1) ? 32'h0000A103 : {8'hA5, 8'(i), 16'h00C3};
            tick();
        end
        check("reset_instr", Instr, 32'h00000013);

        fetch(0);  check("boot_fetch0", Instr, 32'h00500093);
        fetch(4);  check("boot_fetch1", Instr, 32'h0000A103);

        store(8, 32'hDEADBEEF, 1);
        load(8, 0);
        check("lw_after_sw", Read_Data, 32'hDEADBEEF);
        check("count_after_sw", {24'd0, Store_Count}, 32'd1);

        store(10, 32'h1234565A, 0);
        load(10, 1); check("lbu_10", Read_Data, 32'h0000005A);
        load(11, 1); check("lbu_11", Read_Data, 32'h000000DE);
        load(8, 0);  check("lw_after_sb", Read_Data, 32'hDE5ABEEF);

        store(6, 32'hCAFEF00D, 1);
        check("misalign_sw", {31'd0, Misalign}, 32'd1);
        check("count_misaligned", {24'd0, Store_Count}, 32'd2);
        load(4, 0);  check("sw_misaligned_no_write", Read_Data, 32'h0000A103);
        load(9, 0);  check("lw_misaligned", Read_Data, 32'hDE5ABEEF);
        check("misalign_sticky", {31'd0, Misalign}, 32'd1);

        idle(); Mem_Write = 1; PC = 8; Write_Data = 32'h0; tick();
        check("bad_access", {31'd0, Bad_Access}, 32'd1);
        load(8, 0);  check("bad_no_write", Read_Data, 32'hDE5ABEEF);

        // Reset pulse with a simultaneous store that must be dropped.
        idle(); RST = 0; Address_Src = 1; Mem_Write = 1; Store_type = 1;
        ALU_Result = 12; Write_Data = 32'h77777777; tick();
        check("rst_read_data", Read_Data, 32'h0);
        check("rst_flags", {30'd0, Misalign, Bad_Access}, 32'd0);
        check("rst_count", {24'd0, Store_Count}, 32'd0);
        fetch(8);    check("first_run_fetch", Instr, 32'hDE5ABEEF);
        load(12, 0); check("store_dropped_in_reset", Read_Data, 32'hA50300C3);

        // Store to word 0 with Inst_Write held: IR must not change, then refetch sees new data.
        idle(); Inst_Write = 1; PC = 0; Address_Src = 1; Mem_Write = 1; Store_type = 1;
        ALU_Result = 0; Write_Data = 32'h11111111; tick();
        check("ir_hold_during_store", Instr, 32'hDE5ABEEF);
        fetch(0);    check("refetch_after_store", Instr, 32'h11111111);

        for (int i = 0; i < 260; i++) store(16 + (i % 4), 32'(i), 0);
        check("count_saturates", {24'd0, Store_Count}, 32'd255);
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
